ks_sum_pipe: RTL

- Back end of the 24-bit Kogge-Stone mantissa adder.
- Consumes per-bit propagate/generate vectors and carry-in from the PG front stage, then runs the log2 prefix tree across pipeline registers.
- Produces the registered sum and carry-out under a valid/ready handshake.
- Sits between the PG stage and the FP normaliser/rounder.

---
 rtl/ks_pkg.sv | 14 +
 rtl/ks_gp_cell.sv | 14 +
 rtl/ks_sum_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared types and constants for the Kogge-Stone mantissa adder back end.
package ks_pkg;

   localparam int KS_WIDTH  = 24;
   localparam int KS_LEVELS = $clog2(KS_WIDTH);

   typedef struct packed {
      logic p;
      logic g;
   } ks_pg_t;

   typedef ks_pg_t [KS_WIDTH-1:0] ks_pg_vec_t;

endpackage

// File: rtl/ks_gp_cell.sv
// Kogge-Stone black cell: merges a high group (gh,ph) with the adjacent low group (gl,pl).
module ks_gp_cell (
   input  logic gh,
   input  logic ph,
   input  logic gl,
   input  logic pl,
   output logic g,
   output logic p
);

   assign g = gh | (ph & gl);
   assign p = ph & pl;

endmodule

// File: rtl/ks_sum_pipe.sv
// Pipelined Kogge-Stone prefix tree and sum stage, one prefix level per register stage.
// Optional two's-complement overflow output o_ovf when KS_SUM_OVF_EN is defined.
module ks_sum_pipe
   import ks_pkg::*;
#(
   parameter int WIDTH  = KS_WIDTH,
   parameter int LEVELS = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_pk,
   input  logic [WIDTH-1:0] i_gk,
   input  logic             i_c0,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
`ifdef KS_SUM_OVF_EN
   output logic             o_ovf,
`endif
   output logic             o_cout
);

   // Per-level combinational inputs/outputs of the prefix tree.
   logic [WIDTH-1:0] g_in     [1:LEVELS];
   logic [WIDTH-1:0] p_in     [1:LEVELS];
   logic [WIDTH-1:0] g_out    [1:LEVELS];
   logic [WIDTH-1:0] p_out    [1:LEVELS];
   logic [WIDTH-1:0] lvl_pk   [1:LEVELS];
   logic             lvl_c0   [1:LEVELS];
   logic             lvl_vld  [1:LEVELS];

   // Inter-stage registers; register k holds the result of prefix level k.
   ks_pg_t [WIDTH-1:0] pg_reg [1:LEVELS-1];
   logic [WIDTH-1:0]   pk_reg [1:LEVELS-1];
   logic               c0_reg [1:LEVELS-1];
   logic               vld_reg[1:LEVELS-1];

   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;
   logic             out_vld_reg;
   logic             en;

   logic [WIDTH-1:0] fin_carry;
   logic [WIDTH-1:0] fin_sum;
   logic             fin_cout;
   logic             unused_p;

   assign en      = ~out_vld_reg | i_ready;
   assign o_ready = en;
   assign o_valid = out_vld_reg;
   assign o_sum   = sum_reg;
   assign o_cout  = cout_reg;

   genvar gi, gj;
   generate
      for (gi = 1; gi <= LEVELS; gi++) begin : g_lvl
         localparam int D = 1 << (gi - 1);

         if (gi == 1) begin : g_src
            assign lvl_pk[gi]  = i_pk;
            assign lvl_c0[gi]  = i_c0;
            assign lvl_vld[gi] = i_valid;
         end else begin : g_src
            assign lvl_pk[gi]  = pk_reg[gi-1];
            assign lvl_c0[gi]  = c0_reg[gi-1];
            assign lvl_vld[gi] = vld_reg[gi-1];
         end

         for (gj = 0; gj < WIDTH; gj++) begin : g_bit
            if (gi == 1) begin : g_in_src
               // Carry-in is folded into bit 0 generate so the tree needs no extra column.
               if (gj == 0) begin : g_fold
                  assign g_in[gi][gj] = i_gk[0] | (i_pk[0] & i_c0);
               end else begin : g_plain
                  assign g_in[gi][gj] = i_gk[gj];
               end
               assign p_in[gi][gj] = i_pk[gj];
            end else begin : g_in_src
               assign g_in[gi][gj] = pg_reg[gi-1][gj].g;
               assign p_in[gi][gj] = pg_reg[gi-1][gj].p;
            end

            if (gj >= D) begin : g_cell
               ks_gp_cell u_cell (
                  .gh (g_in[gi][gj]),
                  .ph (p_in[gi][gj]),
                  .gl (g_in[gi][gj-D]),
                  .pl (p_in[gi][gj-D]),
                  .g  (g_out[gi][gj]),
                  .p  (p_out[gi][gj])
               );
            end else begin : g_pass
               assign g_out[gi][gj] = g_in[gi][gj];
               assign p_out[gi][gj] = p_in[gi][gj];
            end
         end
      end
   endgenerate

   // Last level resolves every carry, so the sum is formed in the same cycle.
   assign fin_carry = {g_out[LEVELS][WIDTH-2:0], lvl_c0[LEVELS]};
   assign fin_sum   = lvl_pk[LEVELS] ^ fin_carry;
   assign fin_cout  = g_out[LEVELS][WIDTH-1];
   assign unused_p  = ^p_out[LEVELS];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 1; k < LEVELS; k++) begin
            pg_reg[k]  <= '0;
            pk_reg[k]  <= '0;
            c0_reg[k]  <= 1'b0;
            vld_reg[k] <= 1'b0;
         end
         sum_reg     <= '0;
         cout_reg    <= 1'b0;
         out_vld_reg <= 1'b0;
      end else if (en) begin
         for (int k = 1; k < LEVELS; k++) begin
            vld_reg[k] <= lvl_vld[k];
            if (lvl_vld[k]) begin
               for (int i = 0; i < WIDTH; i++) begin
                  pg_reg[k][i].g <= g_out[k][i];
                  pg_reg[k][i].p <= p_out[k][i];
               end
               pk_reg[k] <= lvl_pk[k];
               c0_reg[k] <= lvl_c0[k];
            end
         end
         out_vld_reg <= lvl_vld[LEVELS];
         if (lvl_vld[LEVELS]) begin
            sum_reg  <= fin_sum;
            cout_reg <= fin_cout;
         end
      end
   end

`ifdef KS_SUM_OVF_EN
   logic ovf_reg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ovf_reg <= 1'b0;
      end else if (en && lvl_vld[LEVELS]) begin
         ovf_reg <= fin_carry[WIDTH-1] ^ fin_cout;
      end
   end

   assign o_ovf = ovf_reg;
`endif

endmodule
